// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the immediate-extension stage: upstream valid/ready
// with immediate and mode, downstream valid/ready with extended data and error.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-entry (main + skid) output buffer.
// in_ready depends only on registered state, so out_ready never reaches it.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    imm_extend_pipe_if.slave    bus,
    output logic [15:0]         xfer_cnt
);
    localparam int E = OUT_W - IN_W;

    typedef enum logic [2:0] {
        MODE_ZERO  = 3'd0,
        MODE_SIGN  = 3'd1,
        MODE_ONES  = 3'd2,
        MODE_UPPER = 3'd3,
        MODE_ZBYTE = 3'd4,
        MODE_SBYTE = 3'd5,
        MODE_BROFF = 3'd6,
        MODE_RSVD  = 3'd7
    } mode_e;

    logic [OUT_W-1:0] main_data, skid_data, ext_data, sign_ext;
    logic             main_valid, main_err, skid_valid, skid_err, ext_err;
    logic             accept, xfer;
    mode_e            mode;

    assign mode     = mode_e'(bus.in_mode);
    assign sign_ext = {{E{bus.in_imm[IN_W-1]}}, bus.in_imm};

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (mode)
            MODE_ZERO:  ext_data = {{E{1'b0}}, bus.in_imm};
            MODE_SIGN:  ext_data = sign_ext;
            MODE_ONES:  ext_data = {{E{1'b1}}, bus.in_imm};
            MODE_UPPER: ext_data = {bus.in_imm, {E{1'b0}}};
            MODE_ZBYTE: ext_data = {{(OUT_W-8){1'b0}}, bus.in_imm[7:0]};
            MODE_SBYTE: ext_data = {{(OUT_W-8){bus.in_imm[7]}}, bus.in_imm[7:0]};
            MODE_BROFF: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
            MODE_RSVD:  ext_err  = 1'b1;
            default:    ext_err  = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && !skid_valid;
    assign xfer   = main_valid && bus.out_ready;

    // A skid refill and an accept are mutually exclusive because in_ready is
    // low whenever the skid holds data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (xfer && skid_valid) begin
            main_data  <= skid_data;
            main_err   <= skid_err;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || xfer)) begin
            main_valid <= 1'b1;
            main_data  <= ext_data;
            main_err   <= ext_err;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_err   <= ext_err;
        end else if (xfer) begin
            main_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_err   = main_err;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: reset, mode sweep, backpressure,
// streaming, asynchronous reset with a full buffer and counter saturation.
module tb_imm_extend_pipe;
    logic        clk;
    logic        rst_n;
    logic [15:0] xfer_cnt;
    int          checks;
    int          errors;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input with out_ready high and check it one edge later.
    task automatic send_chk(input string tag, input logic [15:0] imm, input logic [2:0] mode,
                            input logic [31:0] exp, input logic exp_err);
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        tick();
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_data"}, bus.out_data, exp);
        chk({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, exp_err});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First transaction: sign extension, one-cycle latency
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h8001;
        bus.in_mode  = 3'd1;
        tick();
        bus.in_valid = 1'b0;
        chk("first_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("first_data", bus.out_data, 32'hFFFF8001);
        chk("first_err", {31'd0, bus.out_err}, 32'd0);
        chk("first_cnt_before", {16'd0, xfer_cnt}, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("first_cnt_after", {16'd0, xfer_cnt}, 32'd1);
        chk("first_drained", {31'd0, bus.out_valid}, 32'd0);

        // Mode sweep, back-to-back with out_ready held high
        send_chk("m0", 16'h8001, 3'd0, 32'h00008001, 1'b0);
        send_chk("m3", 16'h1234, 3'd3, 32'h12340000, 1'b0);
        send_chk("m5", 16'h0080, 3'd5, 32'hFFFFFF80, 1'b0);
        send_chk("m4", 16'h0080, 3'd4, 32'h00000080, 1'b0);
        send_chk("m6", 16'hFFFF, 3'd6, 32'hFFFFFFFC, 1'b0);
        send_chk("m2", 16'h0001, 3'd2, 32'hFFFF0001, 1'b0);
        send_chk("m7", 16'hABCD, 3'd7, 32'h00000000, 1'b1);
        send_chk("m1pos", 16'h7FFF, 3'd1, 32'h00007FFF, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("sweep_drained", {31'd0, bus.out_valid}, 32'd0);
        chk("sweep_cnt", {16'd0, xfer_cnt}, 32'd9);

        // Backpressure: A to main, B to skid, C held upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 3'd0;
        bus.in_imm    = 16'h000A;
        tick();
        chk("bp_a_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_imm = 16'h000B;
        tick();
        chk("bp_b_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_b_data", bus.out_data, 32'h0000000A);
        bus.in_imm = 16'h000C;
        tick();
        chk("bp_c_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_stable", bus.out_data, 32'h0000000A);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out_b", bus.out_data, 32'h0000000B);
        chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out_c", bus.out_data, 32'h0000000C);
        chk("bp_out_c_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_cnt", {16'd0, xfer_cnt}, 32'd12);

        // Streaming: 20 items, one per cycle, skid never used
        bus.in_valid = 1'b1;
        bus.in_mode  = 3'd0;
        for (int i = 0; i < 20; i++) begin
            bus.in_imm = 16'(i + 16'h0100);
            tick();
            chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("stream_data", bus.out_data, 32'(i + 32'h0100));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_cnt", {16'd0, xfer_cnt}, 32'd32);

        // Asynchronous reset with both entries occupied
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0011;
        tick();
        bus.in_imm = 16'h0022;
        tick();
        bus.in_valid = 1'b0;
        chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_cnt", {16'd0, xfer_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0055;
        tick();
        bus.in_valid = 1'b0;
        chk("arst_first_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("arst_first_data", bus.out_data, 32'h00000055);

        // Saturation of the transfer counter
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk("sat_cnt", {16'd0, xfer_cnt}, 32'h0000FFFF);
        tick();
        chk("sat_hold", {16'd0, xfer_cnt}, 32'h0000FFFF);
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate-extension stage. It widens an IN_W-bit immediate to OUT_W bits under one of eight modes: zero, sign, ones-fill, upper-place, byte zero/sign, branch-offset and reserved. A valid/ready handshake and a two-entry skid buffer connect it to the rest of the pipeline. It sits between instruction decode and the ALU operand mux, and replaces the combinational 16→32 extender.

## Interface
Parameters:
- IN_W, default 16, immediate input width; legal range ≥ 8.
- OUT_W, default 32, extended output width; legal range ≥ IN_W+2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is sampled on clk.
- in_valid  input  1  in_imm/in_mode are valid.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  3  extension mode (see Operation).
- out_valid  output  1  out_data/out_err are valid.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  extended result.
- out_err  output  1  result came from reserved mode 7.
- xfer_cnt  output  16  saturating count of output transfers.

## Operation
- An input is accepted when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Result is computed combinationally from in_imm/in_mode at accept time, then stored with its err bit. Let E = OUT_W−IN_W.
  - Mode 0, ZERO: {E zeros, in_imm}.
  - Mode 1, SIGN: {E copies of in_imm[IN_W−1], in_imm}.
  - Mode 2, ONES: {E ones, in_imm}. This is the legacy fill behaviour, kept for compatibility.
  - Mode 3, UPPER: in_imm placed at [OUT_W−1:E]; low E bits are zero.
  - Mode 4, ZBYTE: zero-extend in_imm[7:0].
  - Mode 5, SBYTE: sign-extend in_imm[7:0] from bit 7.
  - Mode 6, BROFF: SIGN result shifted left 2; the top 2 bits are discarded and the low 2 bits are zero.
  - Mode 7, reserved: data is all zeros and err = 1. All other modes give err = 0.
- Storage consists of a main register (out_*) and a skid register (skid_data, skid_err, skid_valid).
  - Accept with main empty, or with main transferring this cycle and skid empty: result goes to main.
  - Accept while main holds data that is not transferring: result goes to skid.
  - Main transfers while skid_valid: skid moves to main and skid_valid clears. An accept cannot occur in that cycle because in_ready = 0.
  - Main transfers with skid empty and no accept: out_valid clears.
- Ordering is strictly FIFO. No result is ever dropped or duplicated.
- xfer_cnt increments on each output transfer and saturates at 16'hFFFF.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_err = 0.
  - skid_valid = 0, so in_ready = 1.
  - xfer_cnt = 0.
- Latency: an input accepted at edge N is visible on out_data after edge N, one cycle, when main is free.
- Throughput: one result per cycle when out_ready is held at 1.
- in_ready is a pure function of registered state. There is no combinational path from out_ready to in_ready.
- Once out_valid is asserted, out_data and out_err stay stable until the transfer completes.
- Full condition: main and skid both occupied gives in_ready = 0. in_valid held high keeps its data pending upstream.
- Reset mid-operation: both entries are discarded at once and xfer_cnt returns to 0. The first accept after release obeys the latency above.
- Simultaneous accept and transfer with one entry in main: throughput is preserved and the skid stays empty.

## Test plan
- Reset, then mode 1, in_imm = 16'h8001 → out_data = 32'hFFFF8001 one cycle later, err 0, xfer_cnt 1 after transfer.
- Mode sweep with out_ready = 1 (OUT_W = 32):
  - 16'h1234 mode 3 → 32'h12340000.
  - 16'h0080 mode 5 → 32'hFFFFFF80.
  - 16'h0080 mode 4 → 32'h00000080.
  - 16'hFFFF mode 6 → 32'hFFFFFFFC.
  - 16'h0001 mode 2 → 32'hFFFF0001.
  - mode 7 → 32'h0, out_err 1.
- Backpressure: out_ready = 0, send A, B back-to-back → in_ready falls after B. C is held. Release out_ready → outputs A, B, C in order, one per cycle.
- Streaming: in_valid = out_ready = 1 for 20 cycles with an incrementing in_imm, mode 0 → 20 consecutive outputs, skid never used, xfer_cnt = 20.
- Assert rst_n = 0 asynchronously with both entries full → out_valid = 0 and in_ready = 1 immediately, before the next clk edge. No stale data appears after release.
- Saturation: force 65 540 transfers → xfer_cnt holds 16'hFFFF.
